// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: derives round keys 1..10, one per clock, into an 11-entry store.
// Optional macro AES_KEYSCHED_DEC_ORDER_EN: serve keys in reverse order (rd_idx=0 returns key 10).
module aes_key_schedule #(
  parameter int NUM_ROUNDS = 10,
  parameter int IDX_W      = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             start,
  input  logic [0:127]     cipher_key,
  output logic             busy,
  output logic             key_valid,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [0:127]     round_key,
  output logic [1:0]       dbg_state
);

  // Handshake: start is a one-cycle pulse accepted only in IDLE or DONE; it is ignored
  // during EXPAND. key_valid stays high until the next accepted start or reset.
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EXPAND = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic [1:0]       state;
  logic [0:127]     work_key;
  logic [0:127]     next_key;
  logic [7:0]       rcon;
  logic [IDX_W-1:0] cnt;
  logic [0:127]     key_store [0:NUM_ROUNDS];

  logic [31:0] w0, w1, w2, w3, rot_w, sub_w, t_w, n0, n1, n2, n3;

  assign dbg_state = state;

  always_comb begin
    w0       = work_key[0:31];
    w1       = work_key[32:63];
    w2       = work_key[64:95];
    w3       = work_key[96:127];
    rot_w    = {w3[23:0], w3[31:24]};
    sub_w    = {SBOX[rot_w[31:24]], SBOX[rot_w[23:16]], SBOX[rot_w[15:8]], SBOX[rot_w[7:0]]};
    t_w      = sub_w ^ {rcon, 24'h0};
    n0       = w0 ^ t_w;
    n1       = w1 ^ n0;
    n2       = w2 ^ n1;
    n3       = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      key_valid <= 1'b0;
      rcon      <= 8'h01;
      cnt       <= '0;
      work_key  <= '0;
      for (int i = 0; i <= NUM_ROUNDS; i++) key_store[i] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            key_store[0] <= cipher_key;
            work_key     <= cipher_key;
            cnt          <= IDX_W'(1);
            rcon         <= 8'h01;
            busy         <= 1'b1;
            key_valid    <= 1'b0;
            state        <= EXPAND;
          end
        end
        EXPAND: begin
          for (int i = 1; i <= NUM_ROUNDS; i++) begin
            if (cnt == IDX_W'(i)) key_store[i] <= next_key;
          end
          work_key <= next_key;
          // xtime in GF(2^8): 01,02,...,80 then reduces to 1B,36
          rcon     <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
          cnt      <= cnt + IDX_W'(1);
          if (cnt == IDX_W'(NUM_ROUNDS)) begin
            state     <= DONE;
            busy      <= 1'b0;
            key_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    round_key = '0;
    for (int i = 0; i <= NUM_ROUNDS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
`ifdef AES_KEYSCHED_DEC_ORDER_EN
        round_key = key_store[NUM_ROUNDS - i];
`else
        round_key = key_store[i];
`endif
      end
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Bench for aes_key_schedule: reference key expansion built from GF(2^8) arithmetic,
// expected keys queued at start, a monitor checks them when key_valid rises.
module tb_aes_key_schedule;

  logic         Clk;
  logic         Reset_n;
  logic         start;
  logic [0:127] cipher_key;
  logic         busy;
  logic         key_valid;
  logic [3:0]   rd_idx;
  logic [0:127] round_key;
  logic [1:0]   dbg_state;

  logic [3:0]   rd_mon, rd_stim;
  logic         mon_active;
  assign rd_idx = mon_active ? rd_mon : rd_stim;

  aes_key_schedule #(.NUM_ROUNDS(10), .IDX_W(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .cipher_key(cipher_key),
    .busy(busy), .key_valid(key_valid), .rd_idx(rd_idx), .round_key(round_key),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial begin
    Clk = 1'b0;
    forever #50 Clk = ~Clk;
  end
  always @(posedge Clk) cyc <= cyc + 1;

`ifdef AES_KEYSCHED_DEC_ORDER_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  // ---------------- scoreboard state ----------------
  logic [127:0] exp_q[$];
  int           exp_cyc_q[$];
  int           checks = 0;
  int           errors = 0;
  int           done_cnt = 0;
  int           pushed = 0;
  logic [127:0] model_ks [0:10];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box = affine transform of the multiplicative inverse (a^254)
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gf_mul(inv, a);
    if (a == 8'h00) inv = 8'h00;
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox(tmp[31:24]), sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])};
        tmp = tmp ^ {rc, 24'h0};
        rc  = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= 10; r++) model_ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] exp_read(input int rd, input logic [127:0] k0, input logic [127:0] k10);
    // helper only for the fixed-vector spot checks: index 0 / 10 under either ordering
    if (rd == 0)  return DEC ? k10 : k0;
    if (rd == 10) return DEC ? k0 : k10;
    return 128'h0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [127:0] key, input bit push);
    @(negedge Clk);
    cipher_key = key;
    start      = 1'b1;
    if (push) begin
      expand_key(key);
      for (int r = 0; r <= 10; r++) exp_q.push_back(model_ks[r]);
      exp_cyc_q.push_back(cyc + 11);
      pushed++;
    end
    @(negedge Clk);
    start = 1'b0;
    chk("busy_after_start", {127'h0, busy}, 128'h1);
    chk("kv_low_after_start", {127'h0, key_valid}, 128'h0);
  endtask

  task automatic pulse_start(input logic [127:0] key);
    @(negedge Clk);
    cipher_key = key;
    start      = 1'b1;
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 40) begin
      @(negedge Clk);
      n++;
    end
    @(negedge Clk);
    if (done_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL wait_key_valid timeout done=%0d expected=%0d", done_cnt, target);
      done_cnt = target;
    end
  endtask

  task automatic read_stim(input int rd, input string name, input logic [127:0] exp);
    rd_stim = 4'(rd);
    #1;
    chk(name, round_key, exp);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_busy"}, {127'h0, busy}, 128'h0);
    chk({tag, "_kv"}, {127'h0, key_valid}, 128'h0);
    for (int rd = 0; rd < 16; rd++) read_stim(rd, {tag, "_key0"}, 128'h0);
  endtask

  task automatic reset_mid(input string tag);
    #20 Reset_n = 1'b0;
    #1 check_cleared(tag);
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic         kv_prev = 1'b0;
    int           ecyc;
    logic [127:0] ks [0:10];
    logic [127:0] e;
    mon_active = 1'b0;
    rd_mon     = 4'd0;
    forever begin
      @(negedge Clk);
      if (key_valid && !kv_prev) begin
        if (exp_cyc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL kv_unexpected actual=1 expected=0 at cycle %0d", cyc);
        end else begin
          ecyc = exp_cyc_q.pop_front();
          for (int r = 0; r <= 10; r++) ks[r] = exp_q.pop_front();
          chk_int("kv_latency", cyc, ecyc);
          mon_active = 1'b1;
          for (int rd = 0; rd < 16; rd++) begin
            rd_mon = 4'(rd);
            #1;
            e = (rd > 10) ? 128'h0 : (DEC ? ks[10 - rd] : ks[rd]);
            chk($sformatf("round_key[%0d]", rd), round_key, e);
          end
          mon_active = 1'b0;
          done_cnt++;
        end
      end
      kv_prev = key_valid;
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_K1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_SEQ = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SEQ_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  initial begin
    logic [127:0] rk;
    Reset_n    = 1'b0;
    start      = 1'b0;
    cipher_key = '0;
    rd_stim    = 4'd0;
    repeat (3) @(negedge Clk);
    check_cleared("reset");
    Reset_n = 1'b1;

    // FIPS-197 A.1
    do_start(KEY_A1, 1'b1);
    wait_done(pushed);
    read_stim(1, "a1_rd1", DEC ? model_ks[9] : A1_K1);
    read_stim(0, "a1_rd0", exp_read(0, KEY_A1, A1_K10));
    read_stim(10, "a1_rd10", exp_read(10, KEY_A1, A1_K10));
    read_stim(12, "a1_rd12", 128'h0);

    // starts during EXPAND are ignored
    do_start(KEY_A1, 1'b1);
    @(negedge Clk);
    pulse_start(KEY_SEQ);
    pulse_start(~KEY_A1);
    wait_done(pushed);
    read_stim(10, "ign_rd10", exp_read(10, KEY_A1, A1_K10));

    // restart from DONE
    do_start(KEY_SEQ, 1'b1);
    wait_done(pushed);
    read_stim(10, "seq_rd10", exp_read(10, KEY_SEQ, SEQ_K10));

    // reset with counter at 6, then A.1 again
    do_start(KEY_SEQ, 1'b0);
    repeat (5) @(posedge Clk);
    reset_mid("rst_mid");
    do_start(KEY_A1, 1'b1);
    wait_done(pushed);
    read_stim(10, "rst_a1_rd10", exp_read(10, KEY_A1, A1_K10));

    // randomized keys, stray starts, aborted expansions
    for (int it = 0; it < 8; it++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) == 0) begin
        do_start(rk, 1'b0);
        repeat ($urandom_range(1, 8)) @(posedge Clk);
        reset_mid("rand_rst");
        rk = {$urandom, $urandom, $urandom, $urandom};
      end
      do_start(rk, 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 4)) @(negedge Clk);
        pulse_start({$urandom, $urandom, $urandom, $urandom});
      end
      wait_done(pushed);
      repeat ($urandom_range(0, 3)) @(negedge Clk);
    end

    repeat (15) @(negedge Clk);
    chk_int("leftover_expectations", exp_cyc_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
